// File: rtl/riscv_instr_aligner.sv
// rtl/riscv_instr_aligner.sv - IF-stage aligner: splits 32-bit fetch words into RV32/RVC instructions
module riscv_instr_aligner #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_rdata_i,
    output logic        fetch_ready_o,
    output logic        instr_valid_o,
    output logic [31:0] instr_rdata_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_ready_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i
);

    typedef enum logic [1:0] {
        ST_ALIGNED    = 2'd0,
        ST_MISALIGNED = 2'd1,
        ST_BRANCH_MIS = 2'd2
    } state_e;

    state_e      st_q, st_d;
    logic [15:0] residue_q, residue_d;
    logic [31:0] pc_q, pc_d;

    logic [15:0] lo, hi;
    logic        lo_is_rvc, hi_is_rvc, res_is_rvc;
    logic        hs;

    assign lo         = fetch_rdata_i[15:0];
    assign hi         = fetch_rdata_i[31:16];
    assign lo_is_rvc  = (lo[1:0] != 2'b11);
    assign hi_is_rvc  = (hi[1:0] != 2'b11);
    assign res_is_rvc = (residue_q[1:0] != 2'b11);

    always_comb begin
        st_d          = st_q;
        residue_d     = residue_q;
        pc_d          = pc_q;
        instr_valid_o = 1'b0;
        instr_rdata_o = 32'h0;
        fetch_ready_o = 1'b0;
        instr_addr_o  = pc_q;
        hs            = 1'b0;

        // valid never depends on instr_ready_i; only hs and the state updates do
        case (st_q)
            ST_ALIGNED: begin
                instr_valid_o = fetch_valid_i;
                instr_rdata_o = lo_is_rvc ? {16'h0, lo} : fetch_rdata_i;
                hs            = instr_valid_o & instr_ready_i;
                fetch_ready_o = hs;
                if (hs) begin
                    if (lo_is_rvc) begin
                        residue_d = hi;
                        pc_d      = pc_q + 32'd2;
                        st_d      = ST_MISALIGNED;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
            ST_MISALIGNED: begin
                if (res_is_rvc) begin
                    instr_valid_o = 1'b1;
                    instr_rdata_o = {16'h0, residue_q};
                    hs            = instr_ready_i;
                    if (hs) begin
                        pc_d = pc_q + 32'd2;
                        st_d = ST_ALIGNED;
                    end
                end else begin
                    instr_valid_o = fetch_valid_i;
                    instr_rdata_o = {lo, residue_q};
                    hs            = instr_valid_o & instr_ready_i;
                    fetch_ready_o = hs;
                    if (hs) begin
                        residue_d = hi;
                        pc_d      = pc_q + 32'd4;
                    end
                end
            end
            ST_BRANCH_MIS: begin
                if (hi_is_rvc) begin
                    instr_valid_o = fetch_valid_i;
                    instr_rdata_o = {16'h0, hi};
                    hs            = instr_valid_o & instr_ready_i;
                    fetch_ready_o = hs;
                    if (hs) begin
                        pc_d = pc_q + 32'd2;
                        st_d = ST_ALIGNED;
                    end
                end else begin
                    // upper half starts a 32-bit instruction: park it and wait for the next word
                    fetch_ready_o = fetch_valid_i;
                    if (fetch_valid_i) begin
                        residue_d = hi;
                        st_d      = ST_MISALIGNED;
                    end
                end
            end
            default: st_d = ST_ALIGNED;
        endcase

        if (branch_i) begin
            instr_valid_o = 1'b0;
            fetch_ready_o = 1'b0;
            pc_d          = {branch_addr_i[31:1], 1'b0};
            residue_d     = 16'h0;
            st_d          = branch_addr_i[1] ? ST_BRANCH_MIS : ST_ALIGNED;
        end

        if (rst_i) begin
            instr_valid_o = 1'b0;
            fetch_ready_o = 1'b0;
            instr_rdata_o = 32'h0;
            instr_addr_o  = BOOT_ADDR;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q      <= ST_ALIGNED;
            residue_q <= 16'h0;
            pc_q      <= BOOT_ADDR;
        end else begin
            st_q      <= st_d;
            residue_q <= residue_d;
            pc_q      <= pc_d;
        end
    end

endmodule
